// File: rtl/alu_seq_shifter_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_shifter_pkg
// Shared types for the sequential shift/rotate unit: the ALU opcode
// enumeration, the shifter FSM states, flag bit positions and opcode
// classification helpers.
// ---------------------------------------------------------------------------
package alu_seq_shifter_pkg;

   typedef enum logic [5:0] {
      ALU_NOP = 6'd0,
      ALU_ADD = 6'd1,
      ALU_SUB = 6'd2,
      ALU_AND = 6'd3,
      ALU_OR  = 6'd4,
      ALU_XOR = 6'd5,
      ALU_NOT = 6'd6,
      ALU_SHL = 6'd7,
      ALU_SHR = 6'd8,
      ALU_SAL = 6'd9,
      ALU_SAR = 6'd10,
      ALU_ROL = 6'd11,
      ALU_ROR = 6'd12,
      ALU_CMP = 6'd13,
      ALU_MOV = 6'd14
   } alu_op_e;

   typedef enum logic [1:0] {
      SH_IDLE,
      SH_BUSY,
      SH_DONE
   } shifter_state_e;

   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_S = 2;
   localparam int FLAG_V = 3;

   // True for every opcode this unit executes; anything else is op_err.
   function automatic logic is_shift_op(alu_op_e op);
      case (op)
         ALU_SHL, ALU_SHR, ALU_SAL, ALU_SAR, ALU_ROL, ALU_ROR: return 1'b1;
         default:                                              return 1'b0;
      endcase
   endfunction

   // Only the left arithmetic/logical shifts report overflow.
   function automatic logic is_left_shift_op(alu_op_e op);
      return (op == ALU_SHL) || (op == ALU_SAL);
   endfunction

endpackage

// File: rtl/alu_seq_shifter_step.sv
// ---------------------------------------------------------------------------
// alu_seq_shifter_step
// Combinational single step of the shifter: moves value by k bits
// (0..STEP) in the direction/fill selected by op and reports the last bit
// shifted or rotated out.
//   value   in  WIDTH  pre-step value
//   op      in  6      alu_op_e opcode
//   k       in  K_W    step size, 0..STEP
//   shifted out WIDTH  post-step value
//   carry   out 1      last bit moved out (0 when k=0)
// ---------------------------------------------------------------------------
module alu_seq_shifter_step
   import alu_seq_shifter_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int STEP  = 1,
   parameter int K_W   = $clog2(STEP + 1)
) (
   input  logic [WIDTH-1:0] value,
   input  alu_op_e          op,
   input  logic [K_W-1:0]   k,
   output logic [WIDTH-1:0] shifted,
   output logic             carry
);

   // One guard bit beyond each end catches the last bit shifted out:
   // bit WIDTH after a left shift is value[WIDTH-k], bit 0 after a right
   // shift is value[k-1]; both are zero when k=0.
   logic [WIDTH:0]   left_ext;
   logic [WIDTH:0]   right_ext;
   logic [WIDTH:0]   sar_ext;
   logic [WIDTH-1:0] rol_val;
   logic [WIDTH-1:0] ror_val;
   int               k_int;

   always_comb begin
      k_int     = int'(k);
      left_ext  = {1'b0, value} << k_int;
      right_ext = {value, 1'b0} >> k_int;
      sar_ext   = $signed({value, 1'b0}) >>> k_int;
      // A shift by WIDTH yields zero, so k=0 leaves the rotates as identity.
      rol_val   = (value << k_int) | (value >> (WIDTH - k_int));
      ror_val   = (value >> k_int) | (value << (WIDTH - k_int));
   end

   always_comb begin
      shifted = value;
      carry   = 1'b0;
      case (op)
         ALU_SHL, ALU_SAL: begin
            shifted = left_ext[WIDTH-1:0];
            carry   = left_ext[WIDTH];
         end
         ALU_SHR: begin
            shifted = right_ext[WIDTH:1];
            carry   = right_ext[0];
         end
         ALU_SAR: begin
            shifted = sar_ext[WIDTH:1];
            carry   = sar_ext[0];
         end
         ALU_ROL: begin
            shifted = rol_val;
            carry   = left_ext[WIDTH];
         end
         ALU_ROR: begin
            shifted = ror_val;
            carry   = right_ext[0];
         end
         default: begin
            shifted = value;
            carry   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_seq_shifter.sv
// ---------------------------------------------------------------------------
// alu_seq_shifter
// Multi-cycle shift/rotate unit (SHL/SHR/SAL/SAR/ROL/ROR by a variable
// amount, at most STEP bits per cycle) with valid/ready on both sides.
//   clk       in  1      clock
//   rst_n     in  1      asynchronous active-low reset
//   flush     in  1      abort to IDLE (only with ALU_SEQ_SHIFTER_FLUSH_EN)
//   in_valid  in  1      request valid
//   in_ready  out 1      unit can accept a request
//   op        in  6      alu_op_e opcode
//   a         in  WIDTH  operand
//   amt       in  AMT_W  shift amount, 0..WIDTH-1
//   out_valid out 1      result valid
//   out_ready in  1      consumer accepts result
//   result    out WIDTH  shifted/rotated value
//   flags     out 4      {V,S,Z,C}
//   op_err    out 1      last op was not a shift/rotate
// Optional feature macro: ALU_SEQ_SHIFTER_FLUSH_EN (adds the flush port).
// ---------------------------------------------------------------------------
module alu_seq_shifter
   import alu_seq_shifter_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int STEP  = 1,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef ALU_SEQ_SHIFTER_FLUSH_EN
   input  logic             flush,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [AMT_W-1:0] amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             op_err
);

   localparam int K_W = $clog2(STEP + 1);

   shifter_state_e   state_reg, state_next;
   alu_op_e          op_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] val_reg;
   logic [AMT_W-1:0] rem_reg;
   logic [WIDTH-1:0] result_reg;
   logic [3:0]       flags_reg;
   logic             op_err_reg;

   logic             flush_i;
   logic             accept;
   alu_op_e          op_in;
   logic             legal_in;
   logic             zero_path;
   logic [AMT_W:0]   k_full;
   logic [K_W-1:0]   step_k;
   logic             last_step;
   logic [WIDTH-1:0] step_out;
   logic             step_carry;
   logic [3:0]       busy_flags;
   logic [3:0]       pass_flags;

`ifdef ALU_SEQ_SHIFTER_FLUSH_EN
   assign flush_i = flush;
`else
   assign flush_i = 1'b0;
`endif

   assign op_in     = alu_op_e'(op);
   assign legal_in  = is_shift_op(op_in);
   assign accept    = in_valid && in_ready;
   // Zero amounts and illegal opcodes skip BUSY and pass the operand through.
   assign zero_path = !legal_in || (amt == '0);

   // Step size is the remaining count, capped at STEP.
   always_comb begin
      if ({1'b0, rem_reg} < (AMT_W + 1)'(STEP)) begin
         k_full = {1'b0, rem_reg};
      end else begin
         k_full = (AMT_W + 1)'(STEP);
      end
   end

   assign step_k    = K_W'(k_full);
   assign last_step = (state_reg == SH_BUSY) && (rem_reg == AMT_W'(k_full));

   alu_seq_shifter_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP),
      .K_W   (K_W)
   ) u_step (
      .value   (val_reg),
      .op      (op_reg),
      .k       (step_k),
      .shifted (step_out),
      .carry   (step_carry)
   );

   // V compares the final sign against the original operand's sign.
   always_comb begin
      busy_flags         = '0;
      busy_flags[FLAG_C] = step_carry;
      busy_flags[FLAG_Z] = (step_out == '0);
      busy_flags[FLAG_S] = step_out[WIDTH-1];
      busy_flags[FLAG_V] = is_left_shift_op(op_reg) && (step_out[WIDTH-1] != a_reg[WIDTH-1]);
      pass_flags         = '0;
      pass_flags[FLAG_Z] = (a == '0);
      pass_flags[FLAG_S] = a[WIDTH-1];
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= SH_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         SH_IDLE: if (accept)    state_next = zero_path ? SH_DONE : SH_BUSY;
         SH_BUSY: if (last_step) state_next = SH_DONE;
         SH_DONE: if (out_ready) state_next = SH_IDLE;
         default:                state_next = SH_IDLE;
      endcase
      if (flush_i) begin
         state_next = SH_IDLE;
      end
   end

   // Outputs
   always_comb begin
      in_ready  = (state_reg == SH_IDLE) && !flush_i;
      out_valid = (state_reg == SH_DONE);
   end

   assign result = result_reg;
   assign flags  = flags_reg;
   assign op_err = op_err_reg;

   // Datapath; result/flags/op_err only change when an op completes, so they
   // stay put through DONE and across a flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_reg     <= ALU_NOP;
         a_reg      <= '0;
         val_reg    <= '0;
         rem_reg    <= '0;
         result_reg <= '0;
         flags_reg  <= '0;
         op_err_reg <= 1'b0;
      end else begin
         if (accept) begin
            op_reg  <= op_in;
            a_reg   <= a;
            val_reg <= a;
            rem_reg <= zero_path ? '0 : amt;
            if (zero_path) begin
               result_reg <= a;
               flags_reg  <= pass_flags;
               op_err_reg <= !legal_in;
            end
         end else if ((state_reg == SH_BUSY) && !flush_i) begin
            val_reg <= step_out;
            rem_reg <= rem_reg - AMT_W'(k_full);
            if (last_step) begin
               result_reg <= step_out;
               flags_reg  <= busy_flags;
               op_err_reg <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_seq_shifter.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_shifter
// Directed and randomized transactions against a behavioural model of the
// shift/rotate rules; one line printed per transaction.
// ---------------------------------------------------------------------------
module tb_alu_seq_shifter;
   import alu_seq_shifter_pkg::*;

   localparam int W     = 16;
   localparam int STEP  = 4;
   localparam int AMT_W = 4;

   logic             clk;
   logic             rst_n;
`ifdef ALU_SEQ_SHIFTER_FLUSH_EN
   logic             flush;
`endif
   logic             in_valid;
   logic             in_ready;
   logic [5:0]       op;
   logic [W-1:0]     a;
   logic [AMT_W-1:0] amt;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     result;
   logic [3:0]       flags;
   logic             op_err;

   int n_checks = 0;
   int n_fail   = 0;

   alu_seq_shifter #(
      .WIDTH (W),
      .STEP  (STEP),
      .AMT_W (AMT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef ALU_SEQ_SHIFTER_FLUSH_EN
      .flush     (flush),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .amt       (amt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .op_err    (op_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Behavioural reference: whole-amount shifts with plain operators.
   function automatic void model(input logic [5:0] o, input logic [W-1:0] av, input int n,
                                 output logic [W-1:0] r, output logic [3:0] f,
                                 output logic err, output int lat);
      logic c;
      logic v;
      err = 1'b0;
      c   = 1'b0;
      v   = 1'b0;
      case (o)
         6'd7, 6'd9: begin   // SHL, SAL
            r = av << n;
            if (n != 0) c = av[W-n];
            v = (r[W-1] != av[W-1]);
         end
         6'd8: begin         // SHR
            r = av >> n;
            if (n != 0) c = av[n-1];
         end
         6'd10: begin        // SAR
            r = W'($signed(av) >>> n);
            if (n != 0) c = av[n-1];
         end
         6'd11: begin        // ROL: last bit out wraps into bit 0
            r = (av << n) | (av >> (W - n));
            if (n != 0) c = r[0];
         end
         6'd12: begin        // ROR: last bit out wraps into the MSB
            r = (av >> n) | (av << (W - n));
            if (n != 0) c = r[W-1];
         end
         default: begin
            r   = av;
            err = 1'b1;
         end
      endcase
      f   = {v, r[W-1], (r == '0), c};
      lat = err ? 1 : ((n + STEP - 1) / STEP) + 1;
   endfunction

   task automatic run_op(input logic [5:0] o, input logic [W-1:0] av, input int n, input int hold);
      logic [W-1:0] er;
      logic [3:0]   ef;
      logic         ee;
      int           el;
      int           cyc;
      model(o, av, n, er, ef, ee, el);
      @(negedge clk);
      cyc = 0;
      while (!in_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
      op       = o;
      a        = av;
      amt      = AMT_W'(n);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      // Scramble inputs after acceptance; the unit must not look at them.
      in_valid = 1'b0;
      op       = 6'($urandom);
      a        = W'($urandom);
      amt      = AMT_W'($urandom);
      cyc      = 1;
      while (!out_valid && cyc < 50) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("latency", 32'(cyc), 32'(el));
      for (int i = 0; i < hold; i++) begin
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check("hold_result", 32'(result), 32'(er));
         @(posedge clk);
         #1;
         check("hold_out_valid", 32'(out_valid), 32'd1);
      end
      check("result", 32'(result), 32'(er));
      check("flags", 32'(flags), 32'(ef));
      check("op_err", 32'(op_err), 32'(ee));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("post_out_valid", 32'(out_valid), 32'd0);
      check("post_in_ready", 32'(in_ready), 32'd1);
      $display("txn op=%0d a=%h amt=%0d hold=%0d -> result=%h flags=%b op_err=%b latency=%0d",
               o, av, n, hold, result, flags, op_err, cyc);
   endtask

   initial begin
      logic [5:0] ro;
      rst_n     = 1'b0;
`ifdef ALU_SEQ_SHIFTER_FLUSH_EN
      flush     = 1'b0;
`endif
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op        = '0;
      a         = '0;
      amt       = '0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_flags", 32'(flags), 32'd0);
      check("rst_op_err", 32'(op_err), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases
      run_op(6'd7,  16'h8001, 1,  0);   // SHL
      run_op(6'd10, 16'h8000, 15, 0);   // SAR, 4 busy cycles
      run_op(6'd8,  16'h0000, 0,  0);   // SHR amt=0
      run_op(6'd11, 16'h1234, 4,  5);   // ROL with backpressure
      run_op(6'd12, 16'h0001, 1,  0);   // ROR, immediately after handshake
      run_op(6'd1,  16'h00F0, 3,  0);   // ADD -> op_err
      run_op(6'd9,  16'h4000, 1,  0);   // SAL clears op_err, sets V
      run_op(6'd63, 16'h8000, 5,  1);   // unlisted code

      // Reset during BUSY: SHL amt=10 takes three busy cycles
      @(negedge clk);
      op = 6'd7; a = 16'h00FF; amt = 4'd10; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_result", 32'(result), 32'd0);
      check("midrst_flags", 32'(flags), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
         check("midrst_no_valid", 32'(out_valid), 32'd0);
      end

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(3) != 0) ro = 6'(7 + $urandom_range(5));
         else                        ro = 6'($urandom);
         run_op(ro, W'($urandom), int'($urandom_range(W - 1)), int'($urandom_range(3)));
      end

`ifdef ALU_SEQ_SHIFTER_FLUSH_EN
      // Flush mid-BUSY: back to IDLE with no result pulse
      run_op(6'd8, 16'hABCD, 2, 0);
      @(negedge clk);
      op = 6'd7; a = 16'h0F0F; amt = 4'd12; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_in_ready", 32'(in_ready), 32'd1);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      check("flush_result_kept", 32'(result), 32'h2AF3);
      repeat (4) begin
         @(posedge clk);
         #1;
         check("flush_no_valid", 32'(out_valid), 32'd0);
      end
      // Request coincident with flush in IDLE is dropped
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b1; op = 6'd8; a = 16'h1111; amt = 4'd0;
      #1;
      check("flush_blocks_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0; in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         check("flush_req_dropped", 32'(out_valid), 32'd0);
      end
      run_op(6'd11, 16'h8000, 1, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
